// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects and load-use hazard control for a 4-stage ID/EX/MEM/WB pipe.
// Keeps its own copy of the EX/MEM/WB destination info and counts load-use stall cycles.
module fwd_hazard_unit #(
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs_addr_i,
    input  logic [ADDR_W-1:0] id_rt_addr_i,
    input  logic [ADDR_W-1:0] id_write_addr_i,
    input  logic              id_wen_i,
    input  logic              id_is_load_i,
    input  logic              ext_stall_i,
    input  logic              flush_i,
    output logic [1:0]        rs_muxcontrol_o,
    output logic [1:0]        rt_muxcontrol_o,
    output logic              stall_o,
    output logic              bubble_o,
    output logic [CNT_W-1:0]  stall_count_o
);

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] wa;
        logic              wen;
        logic              ld;
    } ex_slot_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] wa;
        logic              wen;
        logic              ld;
    } mem_slot_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] wa;
        logic              wen;
    } wb_slot_t;

    ex_slot_t   ex_q,  ex_d;
    mem_slot_t  mem_q, mem_d;
    wb_slot_t   wb_q,  wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       stall;

    // A slot produces x when it will write x; r0 is hardwired when ZERO_REG is set.
    function automatic logic hit(input logic vld, input logic wen,
                                 input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] x);
        return vld & wen & (wa == x) & !(ZERO_REG && (x == '0));
    endfunction

    // MEM holds the newer value; a load in MEM has no data yet and never forwards.
    function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] x);
        if (hit(mem_q.vld, mem_q.wen, mem_q.wa, x) && !mem_q.ld)
            return 2'd2;
        else if (hit(wb_q.vld, wb_q.wen, wb_q.wa, x))
            return 2'd1;
        else
            return 2'd0;
    endfunction

    always_comb begin
        rs_muxcontrol_o = fwd_sel(ex_q.rs);
        rt_muxcontrol_o = fwd_sel(ex_q.rt);
        stall = id_valid_i & ex_q.vld & ex_q.ld & !flush_i &
                (hit(ex_q.vld, ex_q.wen, ex_q.wa, id_rs_addr_i) |
                 hit(ex_q.vld, ex_q.wen, ex_q.wa, id_rt_addr_i));
        stall_o       = stall;
        bubble_o      = (stall | flush_i) & !ext_stall_i;
        stall_count_o = cnt_q;
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        cnt_d = cnt_q;
        if (!ext_stall_i) begin
            wb_d.vld  = mem_q.vld;
            wb_d.wa   = mem_q.wa;
            wb_d.wen  = mem_q.wen;
            mem_d.vld = ex_q.vld;
            mem_d.wa  = ex_q.wa;
            mem_d.wen = ex_q.wen;
            mem_d.ld  = ex_q.ld;
            if (stall | flush_i) begin
                ex_d = '0;
            end else begin
                ex_d.vld = id_valid_i;
                ex_d.rs  = id_rs_addr_i;
                ex_d.rt  = id_rt_addr_i;
                ex_d.wa  = id_write_addr_i;
                ex_d.wen = id_wen_i;
                ex_d.ld  = id_is_load_i;
            end
            if (stall && (cnt_q != '1))
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (r0 hardwired / 16-bit count, and r0 live / 2-bit count)
// share stimulus and are checked against a pipeline-position model of in-flight instructions.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_wen, id_ld, ext_stall, flush;
    logic [2:0] id_rs, id_rt, id_wa;
    logic [1:0] rs_sel0, rt_sel0, rs_sel1, rt_sel1;
    logic       stall0, stall1, bub0, bub1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    fwd_hazard_unit u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_rs_addr_i(id_rs),
        .id_rt_addr_i(id_rt), .id_write_addr_i(id_wa), .id_wen_i(id_wen), .id_is_load_i(id_ld),
        .ext_stall_i(ext_stall), .flush_i(flush), .rs_muxcontrol_o(rs_sel0),
        .rt_muxcontrol_o(rt_sel0), .stall_o(stall0), .bubble_o(bub0), .stall_count_o(cnt0)
    );

    fwd_hazard_unit #(.ZERO_REG(1'b0), .CNT_W(2)) u_dut_z (
        .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_rs_addr_i(id_rs),
        .id_rt_addr_i(id_rt), .id_write_addr_i(id_wa), .id_wen_i(id_wen), .id_is_load_i(id_ld),
        .ext_stall_i(ext_stall), .flush_i(flush), .rs_muxcontrol_o(rs_sel1),
        .rt_muxcontrol_o(rt_sel1), .stall_o(stall1), .bubble_o(bub1), .stall_count_o(cnt1)
    );

    // In-flight instructions by pipeline distance: [0]=EX, [1]=MEM, [2]=WB. Model m=0 has r0
    // hardwired, m=1 treats r0 as an ordinary register.
    typedef struct {
        bit       v;
        bit [2:0] rs, rt, wa;
        bit       wen, ld;
    } ins_t;

    ins_t pipe [2][3];
    int   cnt_exp [2];
    int   cnt_max [2] = '{65535, 3};
    int   n_vec = 0, n_err = 0;
    int   obs_rs [2], obs_rt [2], obs_stall [2], obs_bub [2], obs_cnt [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit produces(ins_t p, bit [2:0] x, int m);
        return p.v && p.wen && (p.wa == x) && !(m == 0 && x == 3'd0);
    endfunction

    // Newest older producer wins; a load one stage ahead has no data yet, so look further back.
    function automatic int exp_sel(int m, bit [2:0] x);
        for (int d = 1; d <= 2; d++) begin
            if (produces(pipe[m][d], x, m) && !(d == 1 && pipe[m][d].ld))
                return (d == 1) ? 2 : 1;
        end
        return 0;
    endfunction

    function automatic bit exp_stall(int m);
        ins_t e;
        e = pipe[m][0];
        return id_valid && e.ld && !flush &&
               (produces(e, id_rs, m) || produces(e, id_rt, m));
    endfunction

    task automatic model_reset();
        ins_t z;
        z = '{default: 0};
        for (int m = 0; m < 2; m++) begin
            for (int d = 0; d < 3; d++) pipe[m][d] = z;
            cnt_exp[m] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            bit st;
            st = exp_stall(m);
            obs_rs[m]    = (m == 0) ? int'(rs_sel0) : int'(rs_sel1);
            obs_rt[m]    = (m == 0) ? int'(rt_sel0) : int'(rt_sel1);
            obs_stall[m] = (m == 0) ? int'(stall0)  : int'(stall1);
            obs_bub[m]   = (m == 0) ? int'(bub0)    : int'(bub1);
            obs_cnt[m]   = (m == 0) ? int'(cnt0)    : int'(cnt1);
            chk($sformatf("stall%0d", m), obs_stall[m], st);
            chk($sformatf("bubble%0d", m), obs_bub[m], (st || flush) && !ext_stall);
            chk($sformatf("count%0d", m), obs_cnt[m], cnt_exp[m]);
            if (pipe[m][0].v) begin
                chk($sformatf("rs_sel%0d", m), obs_rs[m], exp_sel(m, pipe[m][0].rs));
                chk($sformatf("rt_sel%0d", m), obs_rt[m], exp_sel(m, pipe[m][0].rt));
                assert (!(produces(pipe[m][1], pipe[m][0].rs, m) && pipe[m][1].ld) &&
                        !(produces(pipe[m][1], pipe[m][0].rt, m) && pipe[m][1].ld))
                else $error("load in MEM feeds valid EX source (model %0d)", m);
            end
        end
    endtask

    task automatic advance();
        for (int m = 0; m < 2; m++) begin
            bit   st;
            ins_t n;
            st = exp_stall(m);
            if (!ext_stall) begin
                if (st && cnt_exp[m] < cnt_max[m]) cnt_exp[m]++;
                n = '{default: 0};
                if (!(st || flush)) n = '{id_valid, id_rs, id_rt, id_wa, id_wen, id_ld};
                pipe[m][2] = pipe[m][1];
                pipe[m][1] = pipe[m][0];
                pipe[m][0] = n;
            end
        end
    endtask

    task automatic drive(input bit v, input bit [2:0] rs, input bit [2:0] rt, input bit [2:0] wa,
                         input bit wen, input bit ld, input bit ext, input bit fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_wa = wa;
        id_wen = wen; id_ld = ld; ext_stall = ext; flush = fl;
    endtask

    task automatic step(input bit v, input bit [2:0] rs, input bit [2:0] rt, input bit [2:0] wa,
                        input bit wen, input bit ld, input bit ext, input bit fl);
        @(negedge clk);
        drive(v, rs, rt, wa, wen, ld, ext, fl);
        #1 check_outputs();
        @(posedge clk);
        advance();
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall0"}, stall0, 0);   chk({tag, "_stall1"}, stall1, 0);
        chk({tag, "_bub0"}, bub0, 0);       chk({tag, "_bub1"}, bub1, 0);
        chk({tag, "_cnt0"}, cnt0, 0);       chk({tag, "_cnt1"}, cnt1, 0);
        chk({tag, "_sel0"}, {rs_sel0, rt_sel0}, 0);
        chk({tag, "_sel1"}, {rs_sel1, rt_sel1}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // back-to-back ALU dependency
        step(1, 1, 4, 3, 1, 0, 0, 0);
        step(1, 3, 6, 7, 1, 0, 0, 0);
        nop();
        chk("b2b_rs", obs_rs[0], 2); chk("b2b_rt", obs_rt[0], 0);
        nop(); nop();

        // distance-2 dependency, then same with MEM also writing the register
        step(1, 0, 0, 5, 1, 0, 0, 0);
        step(1, 1, 1, 6, 1, 0, 0, 0);
        step(1, 2, 5, 7, 0, 0, 0, 0);
        nop();
        chk("dist2_rt", obs_rt[0], 1);
        step(1, 0, 0, 5, 1, 0, 0, 0);
        step(1, 1, 1, 5, 1, 0, 0, 0);
        step(1, 2, 5, 7, 0, 0, 0, 0);
        nop();
        chk("memprio_rt", obs_rt[0], 2);
        nop(); nop();

        // load-use
        step(1, 0, 0, 2, 1, 1, 0, 0);
        step(1, 2, 0, 3, 1, 0, 0, 0);
        chk("lu_stall", obs_stall[0], 1); chk("lu_bub", obs_bub[0], 1); chk("lu_cnt0", obs_cnt[0], 0);
        step(1, 2, 0, 3, 1, 0, 0, 0);
        chk("lu_stall_once", obs_stall[0], 0); chk("lu_cnt1", obs_cnt[0], 1);
        nop();
        chk("lu_rs_wb", obs_rs[0], 1);
        nop(); nop();

        // zero register
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 4, 1, 0, 0, 0);
        nop();
        chk("zero_rs_z1", obs_rs[0], 0); chk("zero_rs_z0", obs_rs[1], 2);
        chk("zero_rt_z0", obs_rt[1], 2);
        nop(); nop();

        // external freeze over a pending load-use
        step(1, 0, 0, 2, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 2, 2, 3, 1, 0, 1, 0);
            chk("ext_stall", obs_stall[0], 1); chk("ext_bub", obs_bub[0], 0);
            chk("ext_cnt", obs_cnt[0], 1);
        end
        step(1, 2, 2, 3, 1, 0, 0, 0);
        chk("ext_rel_bub", obs_bub[0], 1); chk("ext_rel_cnt", obs_cnt[0], 1);
        step(1, 2, 2, 3, 1, 0, 0, 0);
        chk("ext_post_cnt", obs_cnt[0], 2); chk("ext_post_stall", obs_stall[0], 0);
        nop();
        chk("ext_rs_wb", obs_rs[0], 1);
        nop(); nop();

        // flush during a hazard
        step(1, 0, 0, 2, 1, 1, 0, 0);
        step(1, 2, 0, 3, 1, 0, 0, 1);
        chk("flush_stall", obs_stall[0], 0); chk("flush_bub", obs_bub[0], 1);
        step(1, 4, 4, 5, 1, 0, 0, 0);
        nop(); nop();

        // asynchronous reset while a stall is showing
        step(1, 0, 0, 2, 1, 1, 0, 0);
        @(negedge clk);
        drive(1, 2, 0, 3, 1, 0, 0, 0);
        #1 check_outputs();
        chk("pre_rst_stall", obs_stall[0], 1);
        rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 2, 1, 1, 0, 0);
            step(1, 2, 0, 3, 1, 0, 0, 0);
            step(1, 2, 0, 3, 1, 0, 0, 0);
        end
        nop();
        chk("sat_cnt16", obs_cnt[0], 5); chk("sat_cnt2", obs_cnt[1], 3);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 8, 3'($urandom), 3'($urandom), 3'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised successor to the two-stage forwarding comparator. The block holds its own pipeline copy of per-stage register addresses, covering the EX, MEM and WB slots. From these it generates 3-way forwarding selects for the instruction in EX, detects load-use hazards, inserts bubbles and stalls ID, and counts stall cycles. It sits beside the ID/EX/MEM/WB datapath and drives the EX operand muxes and the ID/IF hold enables.

Parameters:
ADDR_W, 3, register address width in bits
ZERO_REG, 1, if 1 register address 0 is never a forwarding or hazard source
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_n_i  input  1  asynchronous active-low reset
id_valid_i  input  1  ID holds a real instruction
id_rs_addr_i  input  ADDR_W  ID source register rs
id_rt_addr_i  input  ADDR_W  ID source register rt
id_write_addr_i  input  ADDR_W  ID destination register
id_wen_i  input  1  ID instruction writes the register file
id_is_load_i  input  1  ID instruction is a load
ext_stall_i  input  1  global freeze (memory wait); all slots hold
flush_i  input  1  branch redirect; kills the ID instruction and the EX slot
rs_muxcontrol_o  output  2  EX rs operand select: 0 regfile, 1 WB, 2 MEM
rt_muxcontrol_o  output  2  EX rt operand select, same encoding
stall_o  output  1  load-use stall; ID and IF must hold
bubble_o  output  1  bubble is entering EX this edge
stall_count_o  output  CNT_W  saturating count of stall_o cycles

Behaviour:
- State:
  - EX slot: {valid, rs, rt, wa, wen, ld}
  - MEM slot: {valid, wa, wen, ld}
  - WB slot: {valid, wa, wen}
  - stall counter
- Reset (asynchronous, rst_n_i low):
  - All valid bits and wen bits are 0 and the counter is 0.
  - Outputs are therefore 0: both selects 0, stall_o 0, bubble_o 0, stall_count_o 0.
  - Reset asserted mid-stall drops stall_o at once.
- Producer match for slot S and source x:
  - S.valid & S.wen & (S.wa == x) & !(ZERO_REG & x == 0).
- Forward select for EX source x (combinational from registered slots):
  - 2 if MEM matches and MEM.ld == 0.
  - Otherwise 1 if WB matches.
  - Otherwise 0.
  - MEM has priority over WB because it holds the newer value.
  - A load in MEM matching an EX source is unreachable by construction; the bench checks this with an assertion.
- stall_o (combinational):
  - id_valid_i & EX.valid & EX.ld & EX.wen & !flush_i & (EX.wa matches id_rs_addr_i or id_rt_addr_i, with the zero rule applied).
  - The load-use stall lasts exactly 1 cycle per hazard. After the stall the load is in MEM; if the load reaches WB when the consumer reaches EX, forwarding uses select 1.
- bubble_o = stall_o | flush_i, gated by !ext_stall_i.
- Edge update, in priority order:
  1. ext_stall_i = 1: all slots hold and the counter holds, even if stall_o or flush_i is high.
  2. Otherwise:
     - MEM <= EX and WB <= MEM.
     - EX <= bubble (valid = 0) if stall_o or flush_i; else EX <= ID fields, with valid = id_valid_i.
- Counter:
  - Increments when stall_o & !ext_stall_i.
  - Saturates at all-ones; no wrap.
- Simultaneous events:
  - flush_i together with a hazard: flush wins, stall_o = 0, one bubble.
  - A WB write to the same address the ID instruction reads is not handled here; the register file is write-before-read.
- Latency:
  - Selects are valid in the same cycle as the EX slot contents.
  - An ID instruction's fields appear in EX 1 cycle after the edge on which it advances.

Test Plan:
- Back-to-back ALU dependency: I0 writes r3 (wen=1, ld=0), then I1 reads rs=r3 → when I1 is in EX, rs_muxcontrol_o = 2 and rt_muxcontrol_o = 0.
- Distance-2 dependency: I0 writes r5, an unrelated I1, then I2 reads rt=r5 → rt_muxcontrol_o = 1 with I2 in EX. If I1 also writes r5, rt_muxcontrol_o = 2 (MEM priority).
- Load-use: a load writing r2, then a consumer reading r2 → stall_o = 1 and bubble_o = 1 for exactly 1 cycle, stall_count_o goes 0 → 1, and the consumer in EX then sees select 1.
- Zero register with ZERO_REG=1: a producer writing r0 and a consumer reading r0 → selects stay 0 and no stall. With ZERO_REG=0 the same sequence gives select 2.
- ext_stall_i held 3 cycles during a pending load-use → stall_o stays 1, slots are frozen and the counter does not advance. After release, exactly 1 increment occurs and one bubble is inserted.
- Edge cases:
  - flush_i asserted during a hazard cycle → stall_o = 0 and EX becomes a bubble.
  - rst_n_i pulsed low mid-sequence → all outputs go to 0 asynchronously.
  - Counter preloaded near saturation with CNT_W = 2 → saturates at 3.
